fetch_unit: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline. Sits directly upstream of the decode-stage controller and feeds it.
- Owns the PC and issues one instruction-memory request at a time. Applies branch/jump redirects resolved in decode (pcsrcD, jumpD).
- Presents instrD (opD = instrD[31:26], functD = instrD[5:0]), pcD and pcplus4D to decode.
- Raises fetch_stall to the hazard unit while no instruction is ready.

---
 rtl/fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_fetch_unit.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage and IF/ID pipeline register: owns the PC, keeps one memory request in flight, applies decode redirects.
// Optional build macro FETCH_STALL_CNT_EN adds the stall_cntF fetch-stall cycle counter.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallD,
   input  logic        flushD,
   input  logic        pcsrcD,
   input  logic [31:0] pcbranchD,
   input  logic        jumpD,
   input  logic [31:0] pcjumpD,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic [31:0] inst_rdata,
   input  logic        inst_data_ok,
   output logic [31:0] instrD,
   output logic [31:0] pcD,
   output logic [31:0] pcplus4D,
   output logic        validD,
   output logic        fetch_stall
`ifdef FETCH_STALL_CNT_EN
   ,
   output logic [31:0] stall_cntF
`endif
);

   // state  | meaning
   // S_REQ  | issue request for pcF this cycle
   // S_WAIT | request outstanding, waiting for inst_data_ok
   // S_HOLD | fetched word in fbuf, waiting to enter IF/ID
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pcF;
   logic [31:0] req_pc;
   logic [31:0] fbuf;
   logic [31:0] fbuf_pc;
   logic        discard;

   logic        redirect;
   logic [31:0] target;
   logic        take_fbuf;
   logic        drop_resp;
   logic        ifid_load;
   logic        pc_adv;

   assign redirect = (jumpD | pcsrcD) & ~stallD;
   assign target   = jumpD ? pcjumpD : pcbranchD;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_REQ;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_REQ:   state_nxt = S_WAIT;
         S_WAIT: begin
            if (inst_data_ok) begin
               state_nxt = (discard | redirect) ? S_REQ : S_HOLD;
            end
         end
         S_HOLD: begin
            if (!stallD) begin
               state_nxt = S_REQ;
            end
         end
         default: state_nxt = S_REQ;
      endcase
   end

   always_comb begin
      inst_req  = 1'b0;
      take_fbuf = 1'b0;
      drop_resp = 1'b0;
      ifid_load = 1'b0;
      pc_adv    = 1'b0;
      case (state)
         S_REQ: inst_req = ~rst;
         S_WAIT: begin
            take_fbuf = inst_data_ok & ~discard & ~redirect;
            drop_resp = inst_data_ok & (discard | redirect);
         end
         S_HOLD: begin
            ifid_load = ~stallD & ~redirect & ~flushD;
            pc_adv    = ~stallD & ~redirect;
         end
         default: begin
            inst_req = 1'b0;
         end
      endcase
   end

   assign inst_addr   = pcF;
   assign fetch_stall = (state != S_HOLD) & ~rst;

   // A redirect in S_HOLD has nothing outstanding, so only REQ/WAIT arm discard.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcF     <= RESET_PC;
         req_pc  <= 32'h0;
         fbuf    <= 32'h0;
         fbuf_pc <= 32'h0;
         discard <= 1'b0;
      end else begin
         if (redirect) begin
            pcF <= target;
         end else if (pc_adv) begin
            pcF <= pcF + 32'd4;
         end
         if (state == S_REQ) begin
            req_pc <= pcF;
         end
         if (drop_resp) begin
            discard <= 1'b0;
         end else if (redirect && (state != S_HOLD)) begin
            discard <= 1'b1;
         end
         if (take_fbuf) begin
            fbuf    <= inst_rdata;
            fbuf_pc <= req_pc;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instrD   <= NOP_INSTR;
         pcD      <= 32'h0;
         pcplus4D <= 32'h0;
         validD   <= 1'b0;
      end else if (!stallD) begin
         if (ifid_load) begin
            instrD   <= fbuf;
            pcD      <= fbuf_pc;
            pcplus4D <= fbuf_pc + 32'd4;
            validD   <= 1'b1;
         end else begin
            instrD <= NOP_INSTR;
            validD <= 1'b0;
         end
      end
   end

`ifdef FETCH_STALL_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cntF <= 32'h0;
      end else if (fetch_stall) begin
         stall_cntF <= stall_cntF + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized redirect/stall traffic against an
// instruction-stream reference model (expected PC sequence and memory contents).
module tb_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
   localparam logic [31:0] NOP      = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stallD = 1'b0;
   logic        flushD = 1'b0;
   logic        pcsrcD = 1'b0;
   logic        jumpD = 1'b0;
   logic [31:0] pcbranchD = 32'h0;
   logic [31:0] pcjumpD = 32'h0;
   logic [31:0] inst_rdata = 32'h0;
   logic        inst_data_ok = 1'b0;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic [31:0] instrD;
   logic [31:0] pcD;
   logic [31:0] pcplus4D;
   logic        validD;
   logic        fetch_stall;
`ifdef FETCH_STALL_CNT_EN
   logic [31:0] stall_cntF;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
      .clk          (clk),
      .rst          (rst),
      .stallD       (stallD),
      .flushD       (flushD),
      .pcsrcD       (pcsrcD),
      .pcbranchD    (pcbranchD),
      .jumpD        (jumpD),
      .pcjumpD      (pcjumpD),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_rdata   (inst_rdata),
      .inst_data_ok (inst_data_ok),
      .instrD       (instrD),
      .pcD          (pcD),
      .pcplus4D     (pcplus4D),
      .validD       (validD),
      .fetch_stall  (fetch_stall)
`ifdef FETCH_STALL_CNT_EN
      ,
      .stall_cntF   (stall_cntF)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == RESET_PC) return 32'h2008_0005;
      return {a[7:0], a[31:8]} ^ 32'h3C1D_A5F0;
   endfunction

   // instruction memory: one request at a time, response after lat cycles
   logic        pend = 1'b0;
   int          cnt = 0;
   logic [31:0] paddr = 32'h0;
   int          lat = 1;
   logic        rand_lat = 1'b0;
   logic        inject = 1'b0;

   always @(negedge clk) begin
      #1;
      inst_data_ok = 1'b0;
      if (rst) begin
         pend = 1'b0;
      end else begin
         if (inject) begin
            inst_data_ok = 1'b1;
            inst_rdata   = 32'hDEAD_DEAD;
         end
         if (pend) begin
            if (cnt == 0) begin
               inst_data_ok = 1'b1;
               inst_rdata   = mem_word(paddr);
               pend         = 1'b0;
            end else begin
               cnt--;
            end
         end
         if (inst_req) begin
            chk("single_outstanding", {31'b0, pend}, 32'h0);
            pend  = 1'b1;
            paddr = inst_addr;
            cnt   = (rand_lat ? $urandom_range(1, 4) : lat) - 1;
         end
      end
   end

   // reference model: the delivered stream must follow PC+4 except where a taken redirect restarts it
   logic [31:0] exp_pc = RESET_PC;
   int          n_deliv = 0;
   logic [31:0] p_instr = 32'h0;
   logic [31:0] p_pc = 32'h0;
   logic [31:0] p_pc4 = 32'h0;
   logic        p_valid = 1'b0;
   logic [31:0] exp_cnt = 32'h0;
   logic        fs_late = 1'b0;

   always @(negedge clk) begin
      #2;
      fs_late = fetch_stall;
   end

   always @(posedge clk) begin
      #1;
      if (rst) begin
         exp_pc  = RESET_PC;
         exp_cnt = 32'h0;
         chk("rst_instrD", instrD, NOP);
         chk("rst_validD", {31'b0, validD}, 32'h0);
         chk("rst_pcD", pcD, 32'h0);
         chk("rst_pcplus4D", pcplus4D, 32'h0);
         chk("rst_inst_req", {31'b0, inst_req}, 32'h0);
         chk("rst_fetch_stall", {31'b0, fetch_stall}, 32'h0);
      end else begin
         if (fs_late) exp_cnt = exp_cnt + 32'd1;
         if (stallD) begin
            chk("stall_hold_instrD", instrD, p_instr);
            chk("stall_hold_pcD", pcD, p_pc);
            chk("stall_hold_pcplus4D", pcplus4D, p_pc4);
            chk("stall_hold_validD", {31'b0, validD}, {31'b0, p_valid});
         end else if (jumpD | pcsrcD) begin
            chk("redirect_bubble_valid", {31'b0, validD}, 32'h0);
            chk("redirect_bubble_instr", instrD, NOP);
            exp_pc = jumpD ? pcjumpD : pcbranchD;
         end else if (validD) begin
            chk("deliver_pcD", pcD, exp_pc);
            chk("deliver_pcplus4D", pcplus4D, exp_pc + 32'd4);
            chk("deliver_instrD", instrD, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_deliv++;
         end else begin
            chk("bubble_instr", instrD, NOP);
         end
         if (!fetch_stall) chk("no_req_in_hold", {31'b0, inst_req}, 32'h0);
      end
`ifdef FETCH_STALL_CNT_EN
      chk("stall_cntF", stall_cntF, exp_cnt);
`endif
      p_instr = instrD;
      p_pc    = pcD;
      p_pc4   = pcplus4D;
      p_valid = validD;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_until_hold(input string tag);
      int k = 0;
      while (fetch_stall !== 1'b0 && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk(tag, {31'b0, fetch_stall}, 32'h0);
   endtask

   function automatic logic [31:0] pick_target();
      logic [31:0] v;
      v = $urandom & 32'hFFFF_FFFC;
      case ($urandom_range(0, 7))
         0:       return 32'hFFFF_FFFC;
         1:       return 32'hFFFF_FFF8;
         default: return v;
      endcase
   endfunction

   initial begin
      logic [31:0] s_instr, s_pc;
      logic        s_valid;
      int          k;

      cyc(3);
      // release from reset; 1-cycle memory
      lat = 1;
      rst = 1'b0;
      #1;
      chk("t1_req", {31'b0, inst_req}, 32'h1);
      chk("t1_addr", inst_addr, RESET_PC);
      cyc(3);
      chk("t1_validD", {31'b0, validD}, 32'h1);
      chk("t1_instrD", instrD, 32'h2008_0005);
      chk("t1_pcD", pcD, 32'hBFC0_0000);
      chk("t1_pcplus4D", pcplus4D, 32'hBFC0_0004);
      chk("t1_next_req", {31'b0, inst_req}, 32'h1);
      chk("t1_next_addr", inst_addr, 32'hBFC0_0004);

      // stall 4 cycles in S_HOLD
      wait_until_hold("t2_reach_hold");
      stallD  = 1'b1;
      s_instr = instrD;
      s_pc    = pcD;
      s_valid = validD;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t2_no_req", {31'b0, inst_req}, 32'h0);
         chk("t2_fetch_stall", {31'b0, fetch_stall}, 32'h0);
         chk("t2_instrD_hold", instrD, s_instr);
         chk("t2_pcD_hold", pcD, s_pc);
         chk("t2_validD_hold", {31'b0, validD}, {31'b0, s_valid});
      end
      stallD = 1'b0;
      @(negedge clk);
      chk("t2_validD", {31'b0, validD}, 32'h1);
      chk("t2_pcD", pcD, 32'hBFC0_0004);
      chk("t2_instrD", instrD, mem_word(32'hBFC0_0004));
      chk("t2_resume_req", {31'b0, inst_req}, 32'h1);
      chk("t2_resume_addr", inst_addr, 32'hBFC0_0008);

      // branch taken while waiting on a 3-cycle response
      lat = 3;
      @(negedge clk);
      chk("t3_in_wait", {31'b0, fetch_stall}, 32'h1);
      chk("t3_wait_no_req", {31'b0, inst_req}, 32'h0);
      pcsrcD    = 1'b1;
      pcbranchD = 32'hBFC0_0100;
      @(negedge clk);
      pcsrcD = 1'b0;
      k = 0;
      while (!inst_req && k < 20) begin
         chk("t3_bubble", {31'b0, validD}, 32'h0);
         @(negedge clk);
         k++;
      end
      chk("t3_req", {31'b0, inst_req}, 32'h1);
      chk("t3_addr", inst_addr, 32'hBFC0_0100);

      // jump and branch together in S_HOLD: jump wins
      wait_until_hold("t4_reach_hold");
      jumpD     = 1'b1;
      pcjumpD   = 32'h8000_0000;
      pcsrcD    = 1'b1;
      pcbranchD = 32'h0000_1234;
      @(negedge clk);
      jumpD  = 1'b0;
      pcsrcD = 1'b0;
      chk("t4_validD", {31'b0, validD}, 32'h0);
      chk("t4_instrD", instrD, NOP);
      chk("t4_req", {31'b0, inst_req}, 32'h1);
      chk("t4_addr", inst_addr, 32'h8000_0000);

      // flush while stalled holds, flush unstalled bubbles and consumes the word
      lat = 1;
      wait_until_hold("t5_reach_hold");
      flushD  = 1'b1;
      stallD  = 1'b1;
      s_instr = instrD;
      s_pc    = pcD;
      s_valid = validD;
      @(negedge clk);
      chk("t5_stall_instrD", instrD, s_instr);
      chk("t5_stall_pcD", pcD, s_pc);
      chk("t5_stall_validD", {31'b0, validD}, {31'b0, s_valid});
      chk("t5_stall_in_hold", {31'b0, fetch_stall}, 32'h0);
      stallD = 1'b0;
      @(negedge clk);
      flushD = 1'b0;
      exp_pc = exp_pc + 32'd4;
      chk("t5_validD", {31'b0, validD}, 32'h0);
      chk("t5_instrD", instrD, NOP);
      chk("t5_req", {31'b0, inst_req}, 32'h1);
      chk("t5_addr", inst_addr, 32'h8000_0004);

      // reset while a response is outstanding
      lat = 2;
      @(negedge clk);
      chk("t6_in_wait", {31'b0, fetch_stall}, 32'h1);
      rst = 1'b1;
      cyc(2);
      chk("t6_rst_instrD", instrD, NOP);
      chk("t6_rst_validD", {31'b0, validD}, 32'h0);
      chk("t6_rst_pcD", pcD, 32'h0);
      chk("t6_rst_pcplus4D", pcplus4D, 32'h0);
      chk("t6_rst_req", {31'b0, inst_req}, 32'h0);
      rst    = 1'b0;
      inject = 1'b1;
      #1;
      chk("t6_req", {31'b0, inst_req}, 32'h1);
      chk("t6_addr", inst_addr, RESET_PC);
      @(negedge clk);
      inject = 1'b0;
      chk("t6_stray_validD", {31'b0, validD}, 32'h0);
      chk("t6_stray_instrD", instrD, NOP);
      chk("t6_still_wait", {31'b0, fetch_stall}, 32'h1);
      k = 0;
      while (!validD && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("t6_deliver_pcD", pcD, RESET_PC);
      chk("t6_deliver_instrD", instrD, 32'h2008_0005);

      // randomized traffic
      rand_lat = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (i % 700 == 350) rst = 1'b1;
         if (i % 700 == 352) rst = 1'b0;
         stallD    = ($urandom_range(0, 3) == 0);
         k         = $urandom_range(0, 29);
         pcsrcD    = (k == 0) || (k == 1);
         jumpD     = (k == 1) || (k == 2);
         pcbranchD = pick_target();
         pcjumpD   = pick_target();
         flushD    = pcsrcD | jumpD | (stallD & ($urandom_range(0, 1) == 1));
      end
      @(negedge clk);
      stallD = 1'b0;
      flushD = 1'b0;
      pcsrcD = 1'b0;
      jumpD  = 1'b0;
      cyc(10);
      chk("deliveries_min", {31'b0, (n_deliv >= 100)}, 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
